// File: rtl/drc_pkg.sv
// rtl/drc_pkg.sv - shared types and field helpers for the DVP pixel packer
package drc_pkg;

   // Receive FSM encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DROP = 2'd2
   } drc_state_t;

   // Flag bit positions inside a packed pixel-info word of width info_w
   function automatic int vs_bit(input int info_w);
      return info_w - 1;
   endfunction

   function automatic int hs_bit(input int info_w);
      return info_w - 2;
   endfunction

endpackage

// File: rtl/drc_fwft_fifo.sv
// rtl/drc_fwft_fifo.sv - first-word-fall-through register FIFO with exact occupancy
module drc_fwft_fifo #(
   parameter int DATA_W = 18,
   parameter int DEPTH  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          wr_dat,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          rd_dat,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              rd_ok;
   logic              wr_ok;

   assign empty  = (cnt == '0);
   assign full   = (cnt == CNT_W'(DEPTH));
   assign rd_ok  = rd_en & ~empty;
   // A full FIFO still takes a word when the head leaves in the same cycle
   assign wr_ok  = wr_en & (~full | rd_ok);
   assign rd_dat = mem[rd_ptr];

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_dat;
   end

   // Pointers wrap naturally (power-of-two depth); count tracks 0..DEPTH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
         if (wr_ok && !rd_ok)      cnt <= cnt + CNT_W'(1);
         else if (rd_ok && !wr_ok) cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/drc_pixel_packer_fifo.sv
// rtl/drc_pixel_packer_fifo.sv - DVP byte packer with frame/line flags, FWFT buffer and overflow drop
module drc_pixel_packer_fifo
   import drc_pkg::*;
#(
   parameter int DVP_DATA_W    = 8,
   parameter int BYTES_PER_PXL = 2,
   parameter int PXL_FIFO_D    = 32,
   parameter int PXL_INFO_W    = DVP_DATA_W * BYTES_PER_PXL + 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cam_rx_en,
   input  logic [DVP_DATA_W-1:0]           dvp_d_i,
   input  logic                            dvp_href_i,
   input  logic                            dvp_vsync_i,
   input  logic                            dvp_hsync_i,
   input  logic                            pclk_sync,
   output logic [PXL_INFO_W-1:0]           pxl_info_dat,
   output logic                            pxl_info_vld,
   input  logic                            pxl_info_rdy,
   output logic                            ovf_err_o,
   input  logic                            ovf_clr_i,
   output logic                            drop_o,
   output logic [$clog2(PXL_FIFO_D+1)-1:0] fifo_cnt_o
);

   localparam int PXL_W  = DVP_DATA_W * BYTES_PER_PXL;
   localparam int BCNT_W = (BYTES_PER_PXL > 1) ? $clog2(BYTES_PER_PXL) : 1;
   localparam int VS_BIT = vs_bit(PXL_INFO_W);
   localparam int HS_BIT = hs_bit(PXL_INFO_W);
   localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(BYTES_PER_PXL - 1);

   drc_state_t        state;
   logic              vs_prev, hs_prev;
   logic              vs_pend, hs_pend;
   logic              vs_flag, hs_flag;
   logic              ovf_err;
   logic [BCNT_W-1:0] byte_cnt;
   logic [PXL_W-1:0]  shreg;

   logic              vs_rise, hs_rise;
   logic              active, edge_act, byte_vld;
   logic [BCNT_W-1:0] eff_cnt;
   logic              first_byte, last_byte;
   logic [PXL_W-1:0]  pixel_cur;
   logic              cur_vs, cur_hs;
   logic              push, pop, overflow;
   logic              fifo_empty, fifo_full;
   logic [PXL_INFO_W-1:0] push_word;
   logic [PXL_INFO_W-1:0] head_dat;

   assign vs_rise = dvp_vsync_i & ~vs_prev & cam_rx_en;
   assign hs_rise = dvp_hsync_i & ~hs_prev & cam_rx_en;

   // DROP resumes on the frame-start cycle itself so that byte can open the new frame
   assign active   = cam_rx_en & ((state == RUN) | ((state == DROP) & vs_rise));
   assign edge_act = active & (vs_rise | hs_rise);
   assign byte_vld = active & dvp_href_i & pclk_sync;

   // A sync edge restarts the pixel, so a byte arriving with it is byte 0
   assign eff_cnt    = edge_act ? '0 : byte_cnt;
   assign first_byte = (eff_cnt == '0);
   assign last_byte  = (eff_cnt == LAST_IDX);
   assign pixel_cur  = (first_byte ? '0 : (shreg << DVP_DATA_W)) | PXL_W'(dvp_d_i);
   assign cur_vs     = first_byte ? (vs_pend | vs_rise) : vs_flag;
   assign cur_hs     = first_byte ? (hs_pend | hs_rise) : hs_flag;

   assign push     = byte_vld & last_byte;
   assign pop      = ~fifo_empty & pxl_info_rdy;
   assign overflow = push & fifo_full & ~pop;

   // Assemble the tagged word using the package flag positions
   always_comb begin
      push_word                = '0;
      push_word[PXL_W-1:0]     = pixel_cur;
      push_word[HS_BIT]        = cur_hs;
      push_word[VS_BIT]        = cur_vs;
   end

   drc_fwft_fifo #(
      .DATA_W (PXL_INFO_W),
      .DEPTH  (PXL_FIFO_D)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (push),
      .wr_dat (push_word),
      .rd_en  (pxl_info_rdy),
      .rd_dat (head_dat),
      .empty  (fifo_empty),
      .full   (fifo_full),
      .cnt    (fifo_cnt_o)
   );

   assign pxl_info_vld = ~fifo_empty;
   assign pxl_info_dat = fifo_empty ? '0 : head_dat;
   assign ovf_err_o    = ovf_err;
   assign drop_o       = (state == DROP);

   // Edge history, pending flags and byte packing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_prev  <= 1'b0;
         hs_prev  <= 1'b0;
         vs_pend  <= 1'b0;
         hs_pend  <= 1'b0;
         vs_flag  <= 1'b0;
         hs_flag  <= 1'b0;
         byte_cnt <= '0;
         shreg    <= '0;
      end else begin
         vs_prev <= dvp_vsync_i;
         hs_prev <= dvp_hsync_i;
         if (!cam_rx_en) begin
            vs_pend  <= 1'b0;
            hs_pend  <= 1'b0;
            vs_flag  <= 1'b0;
            hs_flag  <= 1'b0;
            byte_cnt <= '0;
            shreg    <= '0;
         end else if (active) begin
            if (byte_vld) begin
               if (first_byte) begin
                  vs_pend <= 1'b0;
                  hs_pend <= 1'b0;
                  vs_flag <= cur_vs;
                  hs_flag <= cur_hs;
               end
               shreg    <= pixel_cur;
               byte_cnt <= last_byte ? '0 : eff_cnt + BCNT_W'(1);
            end else begin
               vs_pend <= vs_pend | vs_rise;
               hs_pend <= hs_pend | hs_rise;
               if (edge_act) byte_cnt <= '0;
            end
         end
      end
   end

   // Receive FSM and sticky overflow flag (set wins over clear)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ovf_err <= 1'b0;
      end else begin
         if (overflow)       ovf_err <= 1'b1;
         else if (ovf_clr_i) ovf_err <= 1'b0;

         if (!cam_rx_en) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE:    state <= RUN;
               RUN:     if (overflow) state <= DROP;
               DROP:    if (vs_rise) state <= overflow ? DROP : RUN;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_drc_pixel_packer_fifo.sv
// tb/tb_drc_pixel_packer_fifo.sv - scoreboard bench for the DVP pixel packer FIFO
module tb_drc_pixel_packer_fifo;

   localparam int DW    = 8;
   localparam int BPP   = 2;
   localparam int DEPTH = 32;
   localparam int IW    = DW * BPP + 2;
   localparam int PW    = DW * BPP;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cam_rx_en = 1'b0;
   logic [DW-1:0] dvp_d_i = '0;
   logic          dvp_href_i = 1'b0;
   logic          dvp_vsync_i = 1'b0;
   logic          dvp_hsync_i = 1'b0;
   logic          pclk_sync = 1'b0;
   logic [IW-1:0] pxl_info_dat;
   logic          pxl_info_vld;
   logic          pxl_info_rdy = 1'b0;
   logic          ovf_err_o;
   logic          ovf_clr_i = 1'b0;
   logic          drop_o;
   logic [$clog2(DEPTH+1)-1:0] fifo_cnt_o;

   drc_pixel_packer_fifo #(
      .DVP_DATA_W    (DW),
      .BYTES_PER_PXL (BPP),
      .PXL_FIFO_D    (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cam_rx_en    (cam_rx_en),
      .dvp_d_i      (dvp_d_i),
      .dvp_href_i   (dvp_href_i),
      .dvp_vsync_i  (dvp_vsync_i),
      .dvp_hsync_i  (dvp_hsync_i),
      .pclk_sync    (pclk_sync),
      .pxl_info_dat (pxl_info_dat),
      .pxl_info_vld (pxl_info_vld),
      .pxl_info_rdy (pxl_info_rdy),
      .ovf_err_o    (ovf_err_o),
      .ovf_clr_i    (ovf_clr_i),
      .drop_o       (drop_o),
      .fifo_cnt_o   (fifo_cnt_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: words owed by the DUT, receive mode, partial pixel bytes
   logic [IW-1:0] exp_q [$];
   logic [DW-1:0] m_part [$];
   int            m_state = 0;
   bit            m_pvs, m_phs, m_pv, m_ph, m_fv, m_fh, m_ovf;
   bit            g_en = 1'b1;
   bit            g_clr = 1'b0;
   int            g_rdy_mode = 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_part.delete();
      m_state = 0;
      {m_pvs, m_phs, m_pv, m_ph, m_fv, m_fh, m_ovf} = '0;
   endtask

   // One clock of the receive rules applied to the inputs about to be sampled
   task automatic model_step(input bit en, input bit hrs, input logic [DW-1:0] d,
                             input bit vs, input bit hs, input bit rdy, input bit clr);
      bit vr, hr, ovf_now;
      logic [31:0] pix;
      logic [IW-1:0] word;
      vr = vs & ~m_pvs & en;
      hr = hs & ~m_phs & en;
      m_pvs = vs;
      m_phs = hs;
      ovf_now = 1'b0;
      if (!en) begin
         m_state = 0;
         m_part.delete();
         m_pv = 1'b0;
         m_ph = 1'b0;
      end else if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1 || (m_state == 2 && vr)) begin
         m_state = 1;
         if (vr || hr) m_part.delete();
         if (vr) m_pv = 1'b1;
         if (hr) m_ph = 1'b1;
         if (hrs) begin
            if (m_part.size() == 0) begin
               m_fv = m_pv;
               m_fh = m_ph;
               m_pv = 1'b0;
               m_ph = 1'b0;
            end
            m_part.push_back(d);
            if (m_part.size() == BPP) begin
               pix = 0;
               foreach (m_part[i]) pix = (pix << DW) | 32'(m_part[i]);
               word = {m_fv, m_fh, pix[PW-1:0]};
               m_part.delete();
               if (exp_q.size() < DEPTH || (rdy && exp_q.size() > 0)) exp_q.push_back(word);
               else begin
                  ovf_now = 1'b1;
                  m_state = 2;
               end
            end
         end
      end
      if (ovf_now)  m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
   endtask

   task automatic check_status();
      check("drop_o", int'(drop_o), int'(m_state == 2));
      check("ovf_err_o", int'(ovf_err_o), int'(m_ovf));
      check("fifo_cnt_o", int'(fifo_cnt_o), exp_q.size());
   endtask

   task automatic drive(input bit href, input bit strb, input logic [DW-1:0] d,
                        input bit vs, input bit hs);
      bit rdy;
      case (g_rdy_mode)
         0:       rdy = 1'b0;
         1:       rdy = 1'b1;
         2:       rdy = ($urandom % 2) == 0;
         default: rdy = ($urandom % 8) == 0;
      endcase
      cam_rx_en    = g_en;
      dvp_href_i   = href;
      pclk_sync    = strb;
      dvp_d_i      = d;
      dvp_vsync_i  = vs;
      dvp_hsync_i  = hs;
      pxl_info_rdy = rdy;
      ovf_clr_i    = g_clr;
      model_step(g_en, href & strb, d, vs, hs, rdy, g_clr);
   endtask

   task automatic cyc(input bit href, input bit strb, input logic [DW-1:0] d,
                      input bit vs, input bit hs);
      @(posedge clk);
      #1 check_status();
      #1 drive(href, strb, d, vs, hs);
   endtask

   task automatic send_byte(input logic [DW-1:0] d);
      cyc(1'b1, 1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 check_status();
      #1 rst = 1'b1;
      model_reset();
      #1;
      check("rst_vld", int'(pxl_info_vld), 0);
      check("rst_cnt", int'(fifo_cnt_o), 0);
      check("rst_ovf", int'(ovf_err_o), 0);
      check("rst_drop", int'(drop_o), 0);
      check("rst_dat", int'(pxl_info_dat), 0);
      @(posedge clk);
      #2 rst = 1'b0;
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   // Monitor: every pop the DUT presents must match the oldest owed word
   always @(negedge clk) begin
      if (!rst && pxl_info_vld && pxl_info_rdy) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected actual=%h required=none at %0t", pxl_info_dat, $time);
         end else begin
            logic [IW-1:0] e;
            e = exp_q.pop_front();
            if (pxl_info_dat !== e) begin
               errors++;
               $display("FAIL pop_data actual=%h required=%h at %0t", pxl_info_dat, e, $time);
            end
         end
      end
   end

   initial begin
      model_reset();
      #1;
      check("init_vld", int'(pxl_info_vld), 0);
      check("init_cnt", int'(fifo_cnt_o), 0);
      check("init_ovf", int'(ovf_err_o), 0);
      check("init_drop", int'(drop_o), 0);
      @(posedge clk);
      #2 rst = 1'b0;
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);

      // Frame and line start tags, then a plain word
      g_rdy_mode = 1;
      idle(2);
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
      send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
      idle(3);

      // Line start mid-pixel discards the partial byte
      send_byte(8'h11);
      cyc(1'b1, 1'b1, 8'h22, 1'b0, 1'b1);
      send_byte(8'h33);
      idle(3);

      // Fill to full, push with simultaneous pop, then overflow
      g_rdy_mode = 0;
      for (int i = 0; i < DEPTH; i++) begin
         send_byte(DW'(i)); send_byte(DW'(8'h80 + i));
      end
      send_byte(8'hE0);
      g_rdy_mode = 1;
      send_byte(8'hE1);
      g_rdy_mode = 0;
      send_byte(8'hE2); send_byte(8'hE3);
      idle(2);
      for (int i = 0; i < 6; i++) send_byte(8'h5A);
      g_clr = 1'b1; idle(1); g_clr = 1'b0;
      g_rdy_mode = 1;
      idle(40);
      send_byte(8'h44); send_byte(8'h45);
      cyc(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
      send_byte(8'h66);
      send_byte(8'h67); send_byte(8'h68);
      idle(3);

      // Disable after byte 0 with words held; re-enable
      g_rdy_mode = 0;
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin send_byte(8'h30 + DW'(i)); send_byte(8'h40); end
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
      send_byte(8'h77);
      g_en = 1'b0; idle(3);
      g_en = 1'b1; idle(1);
      send_byte(8'h88); send_byte(8'h99);
      g_rdy_mode = 2;
      idle(20);

      // Randomised traffic: light and heavy back-pressure
      for (int ph = 0; ph < 2; ph++) begin
         g_rdy_mode = (ph == 0) ? 2 : 3;
         for (int i = 0; i < 700; i++) begin
            if (($urandom % 250) == 0) g_en = ~g_en;
            g_clr = ($urandom % 50) == 0;
            cyc(($urandom % 3) != 0, ($urandom % 2) == 0, DW'($urandom),
                ($urandom % 60) == 0, ($urandom % 15) == 0);
         end
         g_en = 1'b1; g_clr = 1'b1; g_rdy_mode = 1;
         idle(1);
         g_clr = 1'b0;
         idle(40);
      end

      // Reset mid-line with five words stored
      g_rdy_mode = 0;
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin send_byte(8'hF0 + DW'(i)); send_byte(8'h0F); end
      send_byte(8'hAB);
      check("pre_rst_cnt", int'(fifo_cnt_o), 5);
      do_reset();
      g_rdy_mode = 2;
      idle(2);
      send_byte(8'h12); send_byte(8'h34);
      g_rdy_mode = 1;
      idle(10);
      check("final_owed", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
